rng_arbiter: RTL

RNG_ARBITER -- requirements
Module: rng_arbiter

---
 rtl/rng_arbiter_if.sv | 36 +++
 rtl/rng_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rng_arbiter_if.sv
// Bus between the RNG arbiter, its requesters and the RNG core.
// Parameters: NUM_BITS (random word width), NUM_REQ (requester count).
// Signals:
//   enable      arbiter enable
//   req/ack     per-requester level request and one-cycle completion pulse
//   err         timeout flag, qualified by ack
//   rdata       delivered word, valid while any ack bit is high
//   rng_enable  RNG enable (registered copy of enable)
//   rng_we      RNG read strobe
//   rng_do      RNG output word
//   rng_wait    RNG busy, word not yet valid
// Modports: slave = arbiter side, master = requester/RNG side.
interface rng_arbiter_if #(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned NUM_REQ  = 2
);
  logic                enable;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  ack;
  logic                err;
  logic [NUM_BITS-1:0] rdata;
  logic                rng_enable;
  logic                rng_we;
  logic [NUM_BITS-1:0] rng_do;
  logic                rng_wait;

  modport slave (
    input  enable, req, rng_do, rng_wait,
    output ack, err, rdata, rng_enable, rng_we
  );

  modport master (
    output enable, req, rng_do, rng_wait,
    input  ack, err, rdata, rng_enable, rng_we
  );
endinterface

// File: rtl/rng_arbiter.sv
// Arbitrates up to four requesters for single random words from an RNG core.
// A grant raises rng_we until the RNG drops rng_wait (word captured) or the
// wait budget runs out (err set, word zeroed); the winner then gets a
// one-cycle ack carrying rdata/err.
// Ports: clk, resetn (synchronous, active low), bus (rng_arbiter_if.slave).
// Parameters: NUM_BITS (word width), NUM_REQ (2..4), TIMEOUT (2..255).
// Optional feature: define RNG_ARB_ROUNDROBIN_EN for round-robin arbitration;
// without it the lowest requesting index wins.
module rng_arbiter #(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         resetn,
  rng_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                to_q, to_d;
  logic [NUM_BITS-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                we_q, we_d;
  logic                en_q;

  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;

`ifdef RNG_ARB_ROUNDROBIN_EN
  logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

  // Winner select: scan from the start index with wrap; the last hit in the
  // descending scan is the one closest to the start.
  always_comb begin
    int start;
    grant_found = |bus.req;
    grant_idx   = '0;
`ifdef RNG_ARB_ROUNDROBIN_EN
    start = int'(ptr_q);
`else
    start = 0;
`endif
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      int j;
      j = start + i;
      if (j >= int'(NUM_REQ)) j = j - int'(NUM_REQ);
      if (bus.req[j]) grant_idx = IDX_W'(j);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    ack_d   = '0;
    err_d   = 1'b0;
`ifdef RNG_ARB_ROUNDROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.enable && grant_found) begin
          state_d = READ;
          win_d   = grant_idx;
          we_d    = 1'b1;
          cnt_d   = '0;
          to_d    = 1'b0;
`ifdef RNG_ARB_ROUNDROBIN_EN
          // Pointer holds the next search start: one past the winner.
          ptr_d   = (int'(grant_idx) == int'(NUM_REQ) - 1) ? '0 : grant_idx + IDX_W'(1);
`endif
        end
      end
      READ: begin
        if (!bus.rng_wait) begin
          rdata_d = bus.rng_do;
          state_d = DONE;
          we_d    = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          // Counter would reach TIMEOUT-1 at this edge: give up.
          rdata_d = '0;
          to_d    = 1'b1;
          state_d = DONE;
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        ack_d   = NUM_REQ'(1) << win_q;
        err_d   = to_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      we_q    <= 1'b0;
      en_q    <= 1'b0;
`ifdef RNG_ARB_ROUNDROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      en_q    <= bus.enable;
`ifdef RNG_ARB_ROUNDROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.rng_we     = we_q;
  assign bus.rng_enable = en_q;

endmodule
